maze_step_ctrl: RTL and testbench

MAZE_STEP_CTRL -- requirements
Module: maze_step_ctrl

---
 rtl/maze_step_ctrl.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_maze_step_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_step_ctrl.sv
// -----------------------------------------------------------------------------
// maze_step_ctrl
//
// Step controller for a grid-maze reinforcement-learning agent. Each step it
// accepts a greedy action from the Q block and picks either that action or a
// pseudo-random one (epsilon-greedy). It then applies the action to the agent
// position and ends the episode on goal, on an illegal move or on the step
// limit. After a fixed number of episodes it parks in a terminal DONE state.
//
// Parameters
//   ROWS, COLS     maze size; state index = row*COLS + col
//   ST_W           state width (2**ST_W >= ROWS*COLS)
//   EP_W           episode counter width
//   MAX_STEPS      step limit per episode
//   MAX_EPISODES   episode limit
//   START_ST       state every episode starts from
//   GOAL_ST        goal state
//   WALL_MAP       bit i = 1 marks state i as a wall
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   enb            run enable, active-low (1 freezes the controller)
//   epsilon        exploration threshold; explore when LFSR < epsilon
//   next_action    greedy action: 0 up, 1 down, 2 left, 3 right
//   act_valid      next_action valid
//   act_ready      controller accepts an action this cycle
//   current_st     present state
//   prev_st        state before the last applied move
//   next_action_o  action actually applied
//   episode        completed-episode counter (saturating)
//   step_cnt       steps taken in the current episode
//   fail, finish   one-cycle episode-end pulses (finish wins)
//   new_gen        one-cycle pulse when a new episode starts
//   done           episode limit reached, terminal until reset
// -----------------------------------------------------------------------------
module maze_step_ctrl #(
  parameter int ROWS         = 5,
  parameter int COLS         = 5,
  parameter int ST_W         = 6,
  parameter int EP_W         = 10,
  parameter int MAX_STEPS    = 32,
  parameter int MAX_EPISODES = 256,
  parameter int START_ST     = 0,
  parameter int GOAL_ST      = 24,
  parameter logic [ROWS*COLS-1:0] WALL_MAP = {(ROWS*COLS){1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enb,
  input  logic [15:0]     epsilon,
  input  logic [3:0]      next_action,
  input  logic            act_valid,
  output logic            act_ready,
  output logic [ST_W-1:0] current_st,
  output logic [ST_W-1:0] prev_st,
  output logic [3:0]      next_action_o,
  output logic [EP_W-1:0] episode,
  output logic [7:0]      step_cnt,
  output logic            fail,
  output logic            finish,
  output logic            new_gen,
  output logic            done
);

  localparam int NCELL     = ROWS * COLS;
  localparam int START_ROW = START_ST / COLS;
  localparam int START_COL = START_ST % COLS;

  localparam logic [ST_W-1:0] START_S   = ST_W'(START_ST);
  localparam logic [ST_W-1:0] GOAL_S    = ST_W'(GOAL_ST);
  localparam logic [ST_W-1:0] START_R   = ST_W'(START_ROW);
  localparam logic [ST_W-1:0] START_C   = ST_W'(START_COL);
  localparam logic [ST_W-1:0] COLS_S    = ST_W'(COLS);
  localparam logic [ST_W-1:0] LAST_ROW  = ST_W'(ROWS - 1);
  localparam logic [ST_W-1:0] LAST_COL  = ST_W'(COLS - 1);
  localparam logic [ST_W-1:0] ONE_S     = {{(ST_W-1){1'b0}}, 1'b1};
  localparam logic [ST_W-1:0] ZERO_S    = {ST_W{1'b0}};
  localparam logic [7:0]      STEP_LIM  = 8'(MAX_STEPS);
  localparam logic [EP_W:0]   EP_LIM    = (EP_W+1)'(MAX_EPISODES);
  localparam logic [EP_W:0]   EP_ONE    = {{EP_W{1'b0}}, 1'b1};
  localparam logic [15:0]     LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0]     LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    S_SELECT  = 2'd0,
    S_UPDATE  = 2'd1,
    S_RESTART = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e          state_q;
  logic            armed_q;
  logic [ST_W-1:0] cur_q;
  logic [ST_W-1:0] prev_q;
  // Row/column of cur_q kept alongside it so no divider is needed.
  logic [ST_W-1:0] row_q;
  logic [ST_W-1:0] col_q;
  logic [3:0]      act_q;
  logic [EP_W-1:0] ep_q;
  logic [7:0]      step_q;
  logic            fail_q;
  logic            finish_q;
  logic            new_gen_q;
  logic            done_q;
  logic [15:0]     lfsr_q;

  logic [15:0]     lfsr_d;
  logic [7:0]      step_d;
  logic [EP_W:0]   ep_d;
  logic [ST_W-1:0] target_d;
  logic [ST_W-1:0] trow_d;
  logic [ST_W-1:0] tcol_d;
  logic            handshake_s;
  logic            explore_s;
  logic            edge_s;
  logic            wall_s;
  logic            bad_move_s;
  logic            goal_hit_s;
  logic            fail_d;
  logic            ep_last_s;
  logic            ep_ovf_s;

  // Ready is gated by enb directly so a frozen controller never accepts;
  // armed_q keeps it low until the first edge after reset release.
  always_comb begin
    act_ready   = armed_q & ~enb & (state_q == S_SELECT);
    handshake_s = act_valid & act_ready;
  end

  // Exploration decision and counter increments.
  always_comb begin
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & LFSR_TAPS);
    explore_s = (lfsr_q < epsilon);
    step_d    = step_q + 8'd1;
    ep_d      = {1'b0, ep_q} + EP_ONE;
    ep_last_s = (ep_d == EP_LIM);
    ep_ovf_s  = ep_d[EP_W];
  end

  // Target cell of the latched action; edge_s flags a move off the grid
  // or an undefined action code.
  always_comb begin
    target_d = cur_q;
    trow_d   = row_q;
    tcol_d   = col_q;
    edge_s   = 1'b0;
    case (act_q)
      4'd0: begin
        if (row_q == ZERO_S) begin
          edge_s = 1'b1;
        end else begin
          target_d = cur_q - COLS_S;
          trow_d   = row_q - ONE_S;
        end
      end
      4'd1: begin
        if (row_q == LAST_ROW) begin
          edge_s = 1'b1;
        end else begin
          target_d = cur_q + COLS_S;
          trow_d   = row_q + ONE_S;
        end
      end
      4'd2: begin
        if (col_q == ZERO_S) begin
          edge_s = 1'b1;
        end else begin
          target_d = cur_q - ONE_S;
          tcol_d   = col_q - ONE_S;
        end
      end
      4'd3: begin
        if (col_q == LAST_COL) begin
          edge_s = 1'b1;
        end else begin
          target_d = cur_q + ONE_S;
          tcol_d   = col_q + ONE_S;
        end
      end
      default: begin
        edge_s = 1'b1;
      end
    endcase
  end

  // Wall lookup of the target cell (OR-reduced select keeps the index in range).
  always_comb begin
    wall_s = 1'b0;
    for (int i = 0; i < NCELL; i++) begin
      wall_s = wall_s | (WALL_MAP[i] & (target_d == ST_W'(i)));
    end
  end

  // Episode-end classification; goal beats the step limit.
  always_comb begin
    bad_move_s = edge_s | wall_s;
    goal_hit_s = ~bad_move_s & (target_d == GOAL_S);
    fail_d     = ~goal_hit_s & (bad_move_s | (step_d == STEP_LIM));
  end

  // Controller FSM with all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_SELECT;
      armed_q   <= 1'b0;
      cur_q     <= START_S;
      prev_q    <= START_S;
      row_q     <= START_R;
      col_q     <= START_C;
      act_q     <= 4'd0;
      ep_q      <= {EP_W{1'b0}};
      step_q    <= 8'd0;
      fail_q    <= 1'b0;
      finish_q  <= 1'b0;
      new_gen_q <= 1'b0;
      done_q    <= 1'b0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      armed_q   <= 1'b1;
      // Pulses always drop after one cycle, even while frozen.
      fail_q    <= 1'b0;
      finish_q  <= 1'b0;
      new_gen_q <= 1'b0;
      if (!enb) begin
        case (state_q)
          S_SELECT: begin
            if (handshake_s) begin
              lfsr_q  <= lfsr_d;
              act_q   <= explore_s ? {2'b00, lfsr_q[1:0]} : next_action;
              state_q <= S_UPDATE;
            end
          end
          S_UPDATE: begin
            prev_q <= cur_q;
            step_q <= step_d;
            if (!bad_move_s) begin
              cur_q <= target_d;
              row_q <= trow_d;
              col_q <= tcol_d;
            end
            finish_q <= goal_hit_s;
            fail_q   <= fail_d;
            if (goal_hit_s || fail_d) begin
              state_q <= S_RESTART;
            end else begin
              state_q <= S_SELECT;
            end
          end
          S_RESTART: begin
            cur_q     <= START_S;
            row_q     <= START_R;
            col_q     <= START_C;
            step_q    <= 8'd0;
            new_gen_q <= 1'b1;
            if (!ep_ovf_s) begin
              ep_q <= ep_d[EP_W-1:0];
            end
            if (ep_last_s) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_SELECT;
            end
          end
          S_DONE: begin
            state_q <= S_DONE;
          end
          default: begin
            state_q <= S_SELECT;
          end
        endcase
      end
    end
  end

  assign current_st    = cur_q;
  assign prev_st       = prev_q;
  assign next_action_o = act_q;
  assign episode       = ep_q;
  assign step_cnt      = step_q;
  assign fail          = fail_q;
  assign finish        = finish_q;
  assign new_gen       = new_gen_q;
  assign done          = done_q;

endmodule

// File: tb/tb_maze_step_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for maze_step_ctrl. Two instances: index 0 uses default parameters,
// index 1 has a wall at cell 5, MAX_STEPS=4 and MAX_EPISODES=2. A
// transaction-level model (grid row/col arithmetic, episode bookkeeping,
// arithmetic LFSR) predicts every observed value.
// -----------------------------------------------------------------------------
module tb_maze_step_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_r     [2];
  logic        enb_r       [2];
  logic        act_valid_r [2];
  logic [15:0] eps_r       [2];
  logic [3:0]  nact_r      [2];

  logic        ready_w  [2];
  logic [5:0]  cur_w    [2];
  logic [5:0]  prev_w   [2];
  logic [3:0]  act_o_w  [2];
  logic [9:0]  ep_w     [2];
  logic [7:0]  stp_w    [2];
  logic        fail_w   [2];
  logic        fin_w    [2];
  logic        ngen_w   [2];
  logic        done_w   [2];

  maze_step_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n_r[0]), .enb(enb_r[0]), .epsilon(eps_r[0]),
    .next_action(nact_r[0]), .act_valid(act_valid_r[0]), .act_ready(ready_w[0]),
    .current_st(cur_w[0]), .prev_st(prev_w[0]), .next_action_o(act_o_w[0]),
    .episode(ep_w[0]), .step_cnt(stp_w[0]), .fail(fail_w[0]), .finish(fin_w[0]),
    .new_gen(ngen_w[0]), .done(done_w[0])
  );

  maze_step_ctrl #(.WALL_MAP(25'h0000020), .MAX_STEPS(4), .MAX_EPISODES(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n_r[1]), .enb(enb_r[1]), .epsilon(eps_r[1]),
    .next_action(nact_r[1]), .act_valid(act_valid_r[1]), .act_ready(ready_w[1]),
    .current_st(cur_w[1]), .prev_st(prev_w[1]), .next_action_o(act_o_w[1]),
    .episode(ep_w[1]), .step_cnt(stp_w[1]), .fail(fail_w[1]), .finish(fin_w[1]),
    .new_gen(ngen_w[1]), .done(done_w[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state per instance.
  int          m_cur   [2];
  int          m_prev  [2];
  int          m_step  [2];
  int          m_ep    [2];
  int          m_done  [2];
  logic [3:0]  m_act   [2];
  logic [15:0] m_lfsr  [2];
  int          m_max_steps [2];
  int          m_max_ep    [2];
  logic [24:0] m_wall      [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    int x;
    x = int'(v);
    if (x % 2 == 1) x = (x / 2) ^ 32'h0000B400;
    else x = x / 2;
    return 16'(x);
  endfunction

  task automatic model_reset(input int id);
    m_cur[id] = 0; m_prev[id] = 0; m_step[id] = 0; m_ep[id] = 0;
    m_done[id] = 0; m_act[id] = 4'd0; m_lfsr[id] = 16'hACE1;
  endtask

  task automatic check_reset(input int id);
    check_eq("rst_cur",   32'(cur_w[id]),   32'd0);
    check_eq("rst_prev",  32'(prev_w[id]),  32'd0);
    check_eq("rst_act",   32'(act_o_w[id]), 32'd0);
    check_eq("rst_step",  32'(stp_w[id]),   32'd0);
    check_eq("rst_ep",    32'(ep_w[id]),    32'd0);
    check_eq("rst_fail",  32'(fail_w[id]),  32'd0);
    check_eq("rst_fin",   32'(fin_w[id]),   32'd0);
    check_eq("rst_ngen",  32'(ngen_w[id]),  32'd0);
    check_eq("rst_done",  32'(done_w[id]),  32'd0);
    check_eq("rst_ready", 32'(ready_w[id]), 32'd0);
  endtask

  // Called just after a falling edge; returns there.
  task automatic wait_ready(input int id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ready_w[id]) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    check_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  // One full step: handshake, optional freeze in UPDATE, move, and restart.
  task automatic do_move(input int id, input logic [3:0] act, input logic [15:0] e, input int stall);
    bit ok;
    logic [3:0]  applied;
    logic [24:0] w;
    int r, c, t;
    bit bad, fin, fl;
    wait_ready(id, ok);
    if (!ok) return;
    nact_r[id] = act; eps_r[id] = e; act_valid_r[id] = 1'b1;
    applied = (m_lfsr[id] < e) ? {2'b00, m_lfsr[id][1:0]} : act;
    m_lfsr[id] = lfsr_next(m_lfsr[id]);
    m_act[id] = applied;
    @(negedge clk);
    act_valid_r[id] = 1'b0;
    check_eq("applied_act", 32'(act_o_w[id]), 32'(applied));
    check_eq("busy_ready",  32'(ready_w[id]), 32'd0);
    if (stall > 0) begin
      enb_r[id] = 1'b1;
      repeat (stall) @(negedge clk);
      check_eq("stall_cur",  32'(cur_w[id]), 32'(m_cur[id]));
      check_eq("stall_step", 32'(stp_w[id]), 32'(m_step[id]));
      enb_r[id] = 1'b0;
    end
    @(negedge clk);
    r = m_cur[id] / 5; c = m_cur[id] % 5; t = m_cur[id]; bad = 1'b0;
    case (applied)
      4'd0: if (r == 0) bad = 1'b1; else t = t - 5;
      4'd1: if (r == 4) bad = 1'b1; else t = t + 5;
      4'd2: if (c == 0) bad = 1'b1; else t = t - 1;
      4'd3: if (c == 4) bad = 1'b1; else t = t + 1;
      default: bad = 1'b1;
    endcase
    w = m_wall[id];
    if (!bad && w[t]) bad = 1'b1;
    m_prev[id] = m_cur[id];
    m_step[id] = m_step[id] + 1;
    if (!bad) m_cur[id] = t;
    fin = !bad && (t == 24);
    fl  = !fin && (bad || m_step[id] == m_max_steps[id]);
    check_eq("mv_cur",  32'(cur_w[id]),  32'(m_cur[id]));
    check_eq("mv_prev", 32'(prev_w[id]), 32'(m_prev[id]));
    check_eq("mv_step", 32'(stp_w[id]),  32'(m_step[id]));
    check_eq("mv_fin",  32'(fin_w[id]),  32'(fin));
    check_eq("mv_fail", 32'(fail_w[id]), 32'(fl));
    if (fin || fl) begin
      @(negedge clk);
      m_ep[id] = m_ep[id] + 1;
      m_cur[id] = 0; m_step[id] = 0;
      if (m_ep[id] == m_max_ep[id]) m_done[id] = 1;
      check_eq("rs_ngen",  32'(ngen_w[id]),  32'd1);
      check_eq("rs_fail",  32'(fail_w[id]),  32'd0);
      check_eq("rs_fin",   32'(fin_w[id]),   32'd0);
      check_eq("rs_cur",   32'(cur_w[id]),   32'(m_cur[id]));
      check_eq("rs_step",  32'(stp_w[id]),   32'd0);
      check_eq("rs_ep",    32'(ep_w[id]),    32'(m_ep[id]));
      check_eq("rs_done",  32'(done_w[id]),  32'(m_done[id]));
      check_eq("rs_ready", 32'(ready_w[id]), 32'(m_done[id] == 0));
    end else begin
      check_eq("mv_ready", 32'(ready_w[id]), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [3:0]  ra;
    logic [15:0] re;
    int rs;
    m_max_steps[0] = 32; m_max_ep[0] = 256; m_wall[0] = 25'h0000000;
    m_max_steps[1] = 4;  m_max_ep[1] = 2;   m_wall[1] = 25'h0000020;
    for (int i = 0; i < 2; i++) begin
      rst_n_r[i] = 1'b0; enb_r[i] = 1'b0; act_valid_r[i] = 1'b0;
      eps_r[i] = 16'd0; nact_r[i] = 4'd0;
      model_reset(i);
    end
    #12;
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    rst_n_r[0] = 1'b1; rst_n_r[1] = 1'b1;
    check_eq("ready_after_release", 32'(ready_w[0]), 32'd0);
    @(negedge clk);

    // Reach state 7, then reset in the middle of UPDATE.
    do_move(0, 4'd3, 16'd0, 0);
    do_move(0, 4'd3, 16'd0, 0);
    do_move(0, 4'd1, 16'd0, 0);
    check_eq("at_state7", 32'(cur_w[0]), 32'd7);
    wait_ready(0, ok);
    nact_r[0] = 4'd3; eps_r[0] = 16'd0; act_valid_r[0] = 1'b1;
    @(negedge clk);
    act_valid_r[0] = 1'b0;
    #2 rst_n_r[0] = 1'b0;
    #1 check_reset(0);
    model_reset(0);
    @(negedge clk);
    rst_n_r[0] = 1'b1;
    @(negedge clk);

    // Walk right into the east edge.
    for (int i = 0; i < 5; i++) do_move(0, 4'd3, 16'd0, 0);
    check_eq("east_fail_ep", 32'(ep_w[0]), 32'd1);

    // Down four, right four: finish at the goal on the 8th move.
    for (int i = 0; i < 4; i++) do_move(0, 4'd1, 16'd0, 0);
    for (int i = 0; i < 3; i++) do_move(0, 4'd3, 16'd0, 0);
    check_eq("pre_goal_cur", 32'(cur_w[0]), 32'd23);
    do_move(0, 4'd3, 16'd0, 0);
    check_eq("goal_ep",   32'(ep_w[0]),  32'd2);
    check_eq("goal_step", 32'(stp_w[0]), 32'd0);

    // Randomized steps with greedy/explore/mixed epsilon and freezes.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) ra = 4'($urandom_range(4, 15));
      else ra = 4'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: re = 16'h0000;
        1: re = 16'hFFFF;
        default: re = 16'($urandom);
      endcase
      rs = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_move(0, ra, re, rs);
    end

    // Instance 1: wall at cell 5, then undefined action -> episode limit.
    do_move(1, 4'd1, 16'd0, 0);
    check_eq("wall_cur", 32'(cur_w[1]), 32'd0);
    do_move(1, 4'd9, 16'd0, 0);
    repeat (3) @(negedge clk);
    check_eq("done_held",  32'(done_w[1]),  32'd1);
    check_eq("done_ready", 32'(ready_w[1]), 32'd0);
    rst_n_r[1] = 1'b0;
    @(negedge clk);
    check_reset(1);
    model_reset(1);
    rst_n_r[1] = 1'b1;
    @(negedge clk);

    // Step limit of 4: alternate right/left, fail only on the 4th.
    do_move(1, 4'd3, 16'd0, 0);
    do_move(1, 4'd2, 16'd0, 0);
    do_move(1, 4'd3, 16'd0, 0);
    check_eq("lim_step3", 32'(stp_w[1]), 32'd3);
    do_move(1, 4'd2, 16'd0, 0);
    check_eq("lim_ep", 32'(ep_w[1]), 32'd1);

    // Frozen in SELECT: no ready, no handshake, no state change.
    enb_r[1] = 1'b1;
    nact_r[1] = 4'd3; act_valid_r[1] = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("frz_ready", 32'(ready_w[1]), 32'd0);
    check_eq("frz_cur",   32'(cur_w[1]),   32'd0);
    check_eq("frz_step",  32'(stp_w[1]),   32'd0);
    check_eq("frz_act",   32'(act_o_w[1]), 32'(m_act[1]));
    act_valid_r[1] = 1'b0;
    enb_r[1] = 1'b0;
    @(negedge clk);
    check_eq("frz_cur_after", 32'(cur_w[1]), 32'd0);
    do_move(1, 4'd0, 16'd0, 0);
    check_eq("final_done", 32'(done_w[1]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
